// File: rtl/hazard_pkg.sv
// Shared types for the hazard unit: pipeline slot record,
// index/counter widths and the slot match helper.
package hazard_pkg;

    localparam int REG_IDX_W = 4;
    localparam int VLAT_W    = 3;

    typedef struct packed {
        logic                 valid;
        logic                 wr;
        logic [REG_IDX_W-1:0] rd;
        logic                 vec;
        logic                 load;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    // Source hits a slot: same register file, same index, writer.
    // Scalar r0 is hard-wired zero and never creates a dependency.
    function automatic logic slot_hit(
        slot_t                s,
        logic [REG_IDX_W-1:0] idx,
        logic                 svec
    );
        return s.valid & s.wr & (s.rd == idx) & (s.vec == svec)
             & (svec | (idx != '0));
    endfunction

endpackage

// File: rtl/hazard_unit_vbusy_ctr.sv
// Vector ALU occupancy tracker: counts down VLAT-1 cycles after a
// vector op issues and remembers its destination register.
// Ports: clk, rst_n, start_i (vop enters EX), rd_i (its rd),
//        vbusy_o (unit occupied), vbusy_rd_o (rd of op in flight).
module vbusy_ctr
    import hazard_pkg::*;
#(
    parameter int VLAT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [REG_IDX_W-1:0] rd_i,
    output logic                 vbusy_o,
    output logic [REG_IDX_W-1:0] vbusy_rd_o
);

    localparam logic [VLAT_W-1:0] CNT_LOAD = VLAT_W'(VLAT - 1);

    logic [VLAT_W-1:0]    cnt_q, cnt_d;
    logic [REG_IDX_W-1:0] rd_q, rd_d;

    always_comb begin
        cnt_d = cnt_q;
        rd_d  = rd_q;
        if (start_i) begin
            cnt_d = CNT_LOAD;
            rd_d  = rd_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            rd_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            rd_q  <= rd_d;
        end
    end

    assign vbusy_o    = (cnt_q != '0);
    assign vbusy_rd_o = rd_q;

endmodule

// File: rtl/hazard_unit.sv
// Data/structural hazard detection for a scalar+vector pipeline.
// Ports: ID-stage decode fields in, flush in; stall (comb),
//        OpAForward/OpBForward (registered), vbusy out.
// Build option: HAZARD_FORWARDING_EN enables EX->EX forwarding;
//        without it every scalar EX-slot dependency stalls.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int VLAT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use1,
    input  logic                 id_use2,
    input  logic                 id_svec,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_wr,
    input  logic                 id_load,
    input  logic                 id_vop,
    input  logic                 flush,
    output logic                 stall,
    output logic                 OpAForward,
    output logic                 OpBForward,
    output logic                 vbusy
);

`ifdef HAZARD_FORWARDING_EN
    localparam logic FWD_EN = 1'b1;
`else
    localparam logic FWD_EN = 1'b0;
`endif

    slot_t ex_q, mem_q, wb_q, ex_d;

    logic                 vb_busy;
    logic [REG_IDX_W-1:0] vb_rd;

    logic a_ex, a_mem, a_wb;
    logic b_ex, b_mem, b_wb;
    logic vec_haz, ex_haz, mem_haz, vb_haz, st_haz;
    logic hazard, issue;

    assign a_ex  = id_use1 & slot_hit(ex_q,  id_rs1, id_svec);
    assign a_mem = id_use1 & slot_hit(mem_q, id_rs1, id_svec);
    assign a_wb  = id_use1 & slot_hit(wb_q,  id_rs1, id_svec);
    assign b_ex  = id_use2 & slot_hit(ex_q,  id_rs2, id_svec);
    assign b_mem = id_use2 & slot_hit(mem_q, id_rs2, id_svec);
    assign b_wb  = id_use2 & slot_hit(wb_q,  id_rs2, id_svec);

    // Vector operands have no bypass path: any in-flight writer blocks.
    assign vec_haz = id_svec
                   & (a_ex | a_mem | a_wb | b_ex | b_mem | b_wb);

    // Scalar EX hit is bypassable unless the value comes from a load.
    assign ex_haz  = ~id_svec & (a_ex | b_ex)
                   & (ex_q.load | ~FWD_EN);

    // WB writes in the first half-cycle, so only MEM needs a bubble.
    assign mem_haz = ~id_svec & (a_mem | b_mem);

    assign vb_haz  = vb_busy & id_svec
                   & ((id_use1 & (id_rs1 == vb_rd))
                    | (id_use2 & (id_rs2 == vb_rd)));

    assign st_haz  = id_vop & vb_busy;

    assign hazard = vec_haz | ex_haz | mem_haz | vb_haz | st_haz;
    assign stall  = id_valid & ~flush & hazard;
    assign issue  = id_valid & ~flush & ~stall;

    always_comb begin
        ex_d = SLOT_EMPTY;
        if (issue) begin
            ex_d.valid = 1'b1;
            ex_d.wr    = id_wr;
            ex_d.rd    = id_rd;
            ex_d.vec   = id_svec;
            ex_d.load  = id_load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= SLOT_EMPTY;
            mem_q <= SLOT_EMPTY;
            wb_q  <= SLOT_EMPTY;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

`ifdef HAZARD_FORWARDING_EN
    logic fwd_a_q, fwd_a_d;
    logic fwd_b_q, fwd_b_d;

    // Forward only for an instruction that actually moves into EX.
    assign fwd_a_d = issue & ~id_svec & a_ex & ~ex_q.load;
    assign fwd_b_d = issue & ~id_svec & b_ex & ~ex_q.load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_q <= 1'b0;
            fwd_b_q <= 1'b0;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign OpAForward = fwd_a_q;
    assign OpBForward = fwd_b_q;
`else
    assign OpAForward = 1'b0;
    assign OpBForward = 1'b0;
`endif

    vbusy_ctr #(
        .VLAT(VLAT)
    ) u_vbusy_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (issue & id_vop),
        .rd_i       (id_rd),
        .vbusy_o    (vb_busy),
        .vbusy_rd_o (vb_rd)
    );

    assign vbusy = vb_busy;

    // Load flags of older slots are carried for visibility only.
    logic unused_bits;
    assign unused_bits = mem_q.load ^ wb_q.load;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus
// randomized traffic against an issue-history reference model.
module tb_hazard_unit;

    localparam int VLAT = 3;
`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [3:0] id_rs1, id_rs2, id_rd;
    logic       id_use1, id_use2, id_svec, id_wr, id_load, id_vop;
    logic       flush;
    logic       stall, OpAForward, OpBForward, vbusy;

    int errors = 0;
    int checks = 0;

    hazard_unit #(.VLAT(VLAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use1    (id_use1),
        .id_use2    (id_use2),
        .id_svec    (id_svec),
        .id_rd      (id_rd),
        .id_wr      (id_wr),
        .id_load    (id_load),
        .id_vop     (id_vop),
        .flush      (flush),
        .stall      (stall),
        .OpAForward (OpAForward),
        .OpBForward (OpBForward),
        .vbusy      (vbusy)
    );

    always #5 clk = ~clk;

    // Reference model: a list of issued writers stamped with their
    // issue cycle; age 1/2/3 means the writer sits in EX/MEM/WB.
    typedef struct {
        int       stamp;
        bit [3:0] rd;
        bit       vec;
        bit       load;
    } rec_t;

    rec_t     hist[$];
    int       cyc;
    bit       v_have;
    int       v_stamp;
    bit [3:0] v_rd;
    bit       m_fa_q, m_fb_q;

    function automatic bit m_busy();
        return v_have && ((cyc - v_stamp) < VLAT);
    endfunction

    function automatic void src_eval(input bit [3:0] idx, input bit use_it,
                                     output bit h, output bit f);
        h = 1'b0;
        f = 1'b0;
        if (!use_it) return;
        if (!id_svec && idx == 4'd0) return;
        foreach (hist[i]) begin
            int age;
            age = cyc - hist[i].stamp;
            if (age < 1 || age > 3) continue;
            if (hist[i].rd != idx || hist[i].vec != id_svec) continue;
            if (id_svec) h = 1'b1;
            else if (age == 2) h = 1'b1;
            else if (age == 1) begin
                if (hist[i].load || !FWD) h = 1'b1;
                else f = 1'b1;
            end
        end
        if (m_busy() && id_svec && idx == v_rd) h = 1'b1;
    endfunction

    function automatic void m_eval(output bit st, output bit fa, output bit fb);
        bit ha, hb, xa, xb, live;
        src_eval(id_rs1, id_use1, ha, xa);
        src_eval(id_rs2, id_use2, hb, xb);
        live = id_valid && !flush;
        st = live && (ha || hb || (id_vop && m_busy()));
        fa = live && !st && xa;
        fb = live && !st && xb;
    endfunction

    task automatic model_reset();
        hist.delete();
        cyc     = 10;
        v_have  = 1'b0;
        v_stamp = 0;
        v_rd    = '0;
        m_fa_q  = 1'b0;
        m_fb_q  = 1'b0;
    endtask

    task automatic clk_step();
        bit st, fa, fb;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_eval(st, fa, fb);
            if (id_valid && !flush && !st) begin
                if (id_wr) hist.push_back('{cyc, id_rd, id_svec, id_load});
                if (id_vop) begin
                    v_have  = 1'b1;
                    v_stamp = cyc;
                    v_rd    = id_rd;
                end
            end
            m_fa_q = fa;
            m_fb_q = fb;
            cyc++;
            while (hist.size() > 0 && (cyc - hist[0].stamp) > 3)
                void'(hist.pop_front());
        end
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use1 = 0; id_use2 = 0;
        id_svec = 0; id_rd = 0; id_wr = 0; id_load = 0; id_vop = 0;
        flush = 0;
    endtask

    task automatic id(input bit [3:0] r1, input bit u1,
                      input bit [3:0] r2, input bit u2,
                      input bit sv, input bit [3:0] rd, input bit wr,
                      input bit ld, input bit vop);
        id_valid = 1; id_rs1 = r1; id_use1 = u1; id_rs2 = r2;
        id_use2 = u2; id_svec = sv; id_rd = rd; id_wr = wr;
        id_load = ld; id_vop = vop; flush = 0;
    endtask

    task automatic drain();
        idle();
        repeat (4) clk_step();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        #3;
        id(4'd1, 1, 4'd2, 1, 0, 4'd3, 1, 0, 1);
        @(negedge clk);
        if (stall !== 1'b0) begin errors++;
            $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++;
        if ({vbusy, OpAForward, OpBForward} !== 3'b000) begin errors++;
            $display("FAIL reset_outs got=%b exp=000",
                     {vbusy, OpAForward, OpBForward}); end
        checks++;
        idle();
        clk_step();
        rst_n = 1'b1;
        clk_step();
    endtask

    task automatic test_fwd_alu();
        int n;
        n = FWD ? 0 : 2;
        drain();
        id(4'd0, 0, 4'd0, 0, 0, 4'd3, 1, 0, 0);
        @(negedge clk);
        if (stall !== 1'b0) begin errors++;
            $display("FAIL alu_first got=%b exp=0", stall); end
        checks++;
        clk_step();
        id(4'd3, 1, 4'd9, 1, 0, 4'd4, 1, 0, 0);
        for (int c = 0; c <= n; c++) begin
            @(negedge clk);
            if (stall !== (c < n)) begin errors++;
                $display("FAIL alu_stall c%0d got=%b exp=%b", c, stall, c < n); end
            checks++;
            if (OpAForward !== 1'b0) begin errors++;
                $display("FAIL alu_fwd_early c%0d got=%b exp=0", c, OpAForward); end
            checks++;
            clk_step();
        end
        idle();
        @(negedge clk);
        if ({OpAForward, OpBForward} !== {FWD, 1'b0}) begin errors++;
            $display("FAIL alu_fwd got=%b exp=%b",
                     {OpAForward, OpBForward}, {FWD, 1'b0}); end
        checks++;
        clk_step();
        @(negedge clk);
        if (OpAForward !== 1'b0) begin errors++;
            $display("FAIL alu_fwd_once got=%b exp=0", OpAForward); end
        checks++;
    endtask

    task automatic test_load_use();
        drain();
        id(4'd0, 0, 4'd0, 0, 0, 4'd5, 1, 1, 0);
        clk_step();
        id(4'd1, 1, 4'd5, 1, 0, 4'd6, 1, 0, 0);
        for (int c = 0; c <= 2; c++) begin
            @(negedge clk);
            if (stall !== (c < 2)) begin errors++;
                $display("FAIL load_stall c%0d got=%b exp=%b", c, stall, c < 2); end
            checks++;
            if (OpBForward !== 1'b0) begin errors++;
                $display("FAIL load_fwdb c%0d got=%b exp=0", c, OpBForward); end
            checks++;
            clk_step();
        end
        idle();
        @(negedge clk);
        if (OpBForward !== 1'b0) begin errors++;
            $display("FAIL load_fwdb_ex got=%b exp=0", OpBForward); end
        checks++;
    endtask

    task automatic test_r0();
        drain();
        id(4'd0, 0, 4'd0, 0, 0, 4'd0, 1, 0, 0);
        clk_step();
        id(4'd0, 1, 4'd0, 1, 0, 4'd7, 1, 0, 0);
        @(negedge clk);
        if (stall !== 1'b0) begin errors++;
            $display("FAIL r0_stall got=%b exp=0", stall); end
        checks++;
        clk_step();
        idle();
        @(negedge clk);
        if ({OpAForward, OpBForward} !== 2'b00) begin errors++;
            $display("FAIL r0_fwd got=%b exp=00", {OpAForward, OpBForward}); end
        checks++;
    endtask

    task automatic test_vector();
        drain();
        id(4'd0, 0, 4'd0, 0, 1, 4'd2, 1, 0, 1);
        @(negedge clk);
        if (stall !== 1'b0 || vbusy !== 1'b0) begin errors++;
            $display("FAIL vec_first got=%b%b exp=00", stall, vbusy); end
        checks++;
        clk_step();
        id(4'd2, 1, 4'd8, 0, 1, 4'd6, 1, 0, 1);
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            if (stall !== (c < 3)) begin errors++;
                $display("FAIL vec_stall c%0d got=%b exp=%b", c, stall, c < 3); end
            checks++;
            if (vbusy !== (c < 2)) begin errors++;
                $display("FAIL vec_busy c%0d got=%b exp=%b", c, vbusy, c < 2); end
            checks++;
            clk_step();
        end
        idle();
        @(negedge clk);
        if (vbusy !== (VLAT > 1)) begin errors++;
            $display("FAIL vec_busy2 got=%b exp=%b", vbusy, VLAT > 1); end
        checks++;
    endtask

    task automatic test_flush();
        drain();
        id(4'd0, 0, 4'd0, 0, 0, 4'd5, 1, 1, 0);
        clk_step();
        id(4'd5, 1, 4'd0, 0, 0, 4'd7, 1, 1, 0);
        flush = 1'b1;
        @(negedge clk);
        if (stall !== 1'b0) begin errors++;
            $display("FAIL flush_stall got=%b exp=0", stall); end
        checks++;
        clk_step();
        id(4'd7, 1, 4'd0, 0, 0, 4'd8, 1, 0, 0);
        @(negedge clk);
        if (stall !== 1'b0) begin errors++;
            $display("FAIL flush_bubble got=%b exp=0", stall); end
        checks++;
        clk_step();
        idle();
        @(negedge clk);
        if (OpAForward !== 1'b0) begin errors++;
            $display("FAIL flush_fwd got=%b exp=0", OpAForward); end
        checks++;
    endtask

    task automatic test_async_reset();
        drain();
        id(4'd0, 0, 4'd0, 0, 1, 4'd2, 1, 0, 1);
        clk_step();
        id(4'd1, 0, 4'd0, 0, 1, 4'd4, 1, 0, 1);
        @(negedge clk);
        if (vbusy !== 1'b1 || stall !== 1'b1) begin errors++;
            $display("FAIL areset_pre got=%b%b exp=11", vbusy, stall); end
        checks++;
        #1 rst_n = 1'b0;
        #1;
        if ({vbusy, OpAForward, OpBForward, stall} !== 4'b0000) begin errors++;
            $display("FAIL areset_clear got=%b exp=0000",
                     {vbusy, OpAForward, OpBForward, stall}); end
        checks++;
        idle();
        clk_step();
        rst_n = 1'b1;
        clk_step();
        @(negedge clk);
        if (vbusy !== 1'b0) begin errors++;
            $display("FAIL areset_post got=%b exp=0", vbusy); end
        checks++;
    endtask

    task automatic test_random();
        bit st, fa, fb, held;
        held = 1'b0;
        drain();
        for (int k = 0; k < 600; k++) begin
            if (!held) begin
                id_valid = ($urandom % 5) != 0;
                id_rs1   = 4'($urandom % 4);
                id_rs2   = 4'($urandom % 4);
                id_rd    = 4'($urandom % 4);
                id_use1  = 1'($urandom);
                id_use2  = 1'($urandom);
                id_svec  = ($urandom % 3) == 0;
                id_vop   = id_svec && (($urandom % 2) == 0);
                id_load  = !id_svec && (($urandom % 3) == 0);
                id_wr    = ($urandom % 4) != 0;
            end
            flush = ($urandom % 10) == 0;
            @(negedge clk);
            m_eval(st, fa, fb);
            if (stall !== st) begin errors++;
                $display("FAIL rnd_stall k%0d got=%b exp=%b", k, stall, st); end
            checks++;
            if (vbusy !== m_busy()) begin errors++;
                $display("FAIL rnd_vbusy k%0d got=%b exp=%b", k, vbusy, m_busy()); end
            checks++;
            if ({OpAForward, OpBForward} !== {m_fa_q, m_fb_q}) begin errors++;
                $display("FAIL rnd_fwd k%0d got=%b exp=%b", k,
                         {OpAForward, OpBForward}, {m_fa_q, m_fb_q}); end
            checks++;
            held = st;
            clk_step();
        end
    endtask

    initial begin
        test_reset();
        test_fwd_alu();
        test_load_use();
        test_r0();
        test_vector();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
